// File: rtl/multicycle_core_seq.sv
// rtl/multicycle_core_seq.sv - multi-cycle fetch/execute/memory/writeback sequencer
module multicycle_core_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1024,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_ebreak,
  input  logic [31:0]      exu_pc_next,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_we,
  input  logic             dmem_rsp_valid,
  input  logic [31:0]      dmem_rsp_data,
  output logic [31:0]      load_data,
  output logic             rf_wen,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_IWAIT, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT, S_ERROR
  } state_t;

  // Last wait count that may still make progress before the handshake is declared dead
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic        waiting;

  assign waiting = (state == S_FETCH) || (state == S_IWAIT) ||
                   (state == S_MEM)   || (state == S_MWAIT);

  // Outputs decode from state; gated by reset so the reset state (FETCH) issues nothing while held
  assign imem_req_valid = rst && (state == S_FETCH);
  assign imem_addr      = pc;
  assign dmem_req_valid = rst && (state == S_MEM);
  assign dmem_we        = rst && (state == S_MEM) && dec_mem_write;
  assign rf_wen         = rst && (state == S_WB) && dec_reg_write;
  assign halt           = rst && (state == S_HALT);
  assign err            = rst && (state == S_ERROR);

  // Next-state: normal sequencing, then a stalled handshake at its last allowed cycle overrides to ERROR
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (imem_req_ready) state_next = S_IWAIT;
      S_IWAIT: if (imem_rsp_valid) state_next = S_EXEC;
      S_EXEC: begin
        if (dec_ebreak)                         state_next = S_HALT;
        else if (dec_mem_read || dec_mem_write) state_next = S_MEM;
        else                                    state_next = S_WB;
      end
      S_MEM:   if (dmem_req_ready) state_next = S_MWAIT;
      S_MWAIT: if (dmem_rsp_valid) state_next = S_WB;
      S_WB:    state_next = (exu_pc_next[1:0] != 2'b00) ? S_ERROR : S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase
    if ((TIMEOUT != 16'd0) && waiting && (wait_cnt == TMO_LAST) && (state_next == state))
      state_next = S_ERROR;
  end

  // State register and per-state wait counter (restarts on every transition)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) wait_cnt <= '0;
      else if (waiting)        wait_cnt <= wait_cnt + 16'd1;
      else                     wait_cnt <= '0;
    end
  end

  // Architectural registers: instruction latch, load latch, PC commit in WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst      <= '0;
      load_data <= '0;
      pc        <= RESET_PC;
    end else begin
      if ((state == S_IWAIT) && imem_rsp_valid)                   inst      <= imem_rsp_data;
      if ((state == S_MWAIT) && dmem_rsp_valid && !dec_mem_write) load_data <= dmem_rsp_data;
      if (state == S_WB)                                          pc        <= exu_pc_next;
    end
  end

  // Counters: cycles run until HALT/ERROR; ebreak retires on its way into HALT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state != S_HALT) && (state != S_ERROR)) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((state == S_WB) || ((state == S_EXEC) && dec_ebreak))
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_core_seq.sv
// tb/tb_multicycle_core_seq.sv - timeline-model bench for multicycle_core_seq
module tb_multicycle_core_seq;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int          CW  = 4;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LW    = 32'h0000_2083;
  localparam logic [31:0] I_SW    = 32'h0010_2023;
  localparam logic [31:0] I_JAL2  = 32'h0020_006f;
  localparam logic [31:0] I_EBRK  = 32'h0010_0073;

  logic          clk;
  logic          rst;
  logic          imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0]   imem_addr, imem_rsp_data, inst, pc, exu_pc_next;
  logic          dec_mem_read, dec_mem_write, dec_reg_write, dec_ebreak;
  logic          dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0]   dmem_rsp_data, load_data;
  logic          rf_wen, halt, err;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  multicycle_core_seq #(.RESET_PC(RPC), .TIMEOUT(16'd8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst(inst), .pc(pc),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_ebreak(dec_ebreak), .exu_pc_next(exu_pc_next),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .load_data(load_data), .rf_wen(rf_wen), .halt(halt), .err(err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // Stand-in IDU/EXU decoding the latched instruction
  assign dec_mem_read  = (inst[6:0] == 7'h03);
  assign dec_mem_write = (inst[6:0] == 7'h23);
  assign dec_reg_write = (inst[6:0] == 7'h13) || (inst[6:0] == 7'h03) || (inst[6:0] == 7'h6f);
  assign dec_ebreak    = (inst == I_EBRK);
  assign exu_pc_next   = (inst[6:0] == 7'h6f) ? pc + {{20{inst[31]}}, inst[31:20]} : pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model: architectural state plus the outputs expected in the current cycle
  logic [31:0] m_pc, m_inst, m_ld, m_cycle, m_instret;
  bit m_stop, m_rst;
  bit e_ivalid, e_dvalid, e_we, e_wen, e_halt, e_err;

  function automatic logic [31:0] wrap(input logic [31:0] v);
    return v & ((32'd1 << CW) - 32'd1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req_valid", 32'(imem_req_valid), 32'(e_ivalid));
      if (e_ivalid) check("imem_addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("dmem_req_valid", 32'(dmem_req_valid), 32'(e_dvalid));
      if (e_dvalid) check("dmem_we", 32'(dmem_we), 32'(e_we));
      check("rf_wen", 32'(rf_wen), 32'(e_wen));
      check("halt", 32'(halt), 32'(e_halt));
      check("err", 32'(err), 32'(e_err));
      check("cycle_cnt", 32'(cycle_cnt), m_cycle);
      check("instret_cnt", 32'(instret_cnt), m_instret);
      check("inst", inst, m_inst);
      check("load_data", load_data, m_ld);
    end
  end

  task automatic clear_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_inst = '0; m_ld = '0; m_cycle = '0; m_instret = '0;
    m_stop = 1'b0; m_rst = 1'b1;
    e_ivalid = 1'b0; e_dvalid = 1'b0; e_we = 1'b0; e_wen = 1'b0; e_halt = 1'b0; e_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!m_stop && !m_rst) m_cycle = wrap(m_cycle + 32'd1);
  endtask

  task automatic release_reset();
    tick();
    tick();
    rst = 1'b1;
    m_rst = 1'b0;
    e_ivalid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    release_reset();
  endtask

  // One instruction: a/b/c/d are the extra stall cycles for imem ready, imem rsp, dmem ready, dmem rsp
  task automatic run_inst(input logic [31:0] word, input int a, input int b, input int c,
                          input int d, input logic [31:0] rdata, input bit abort);
    bit is_ld, is_st, wen, brk;
    logic [31:0] nxt;
    is_ld = (word[6:0] == 7'h03);
    is_st = (word[6:0] == 7'h23);
    brk   = (word == I_EBRK);
    wen   = (word[6:0] == 7'h13) || is_ld || (word[6:0] == 7'h6f);
    nxt   = (word[6:0] == 7'h6f) ? m_pc + {{20{word[31]}}, word[31:20]} : m_pc + 32'd4;
    for (int t = 0; t <= a; t++) begin
      e_ivalid = 1'b1;
      imem_req_ready = (t == a);
      imem_rsp_valid = (t == a);
      imem_rsp_data  = 32'hBADB_AD00;
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h0BAD_0BAD;
      tick();
    end
    e_ivalid = 1'b0;
    clear_inputs();
    for (int t = 0; t <= b; t++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = (t == b);
      imem_rsp_data  = (t == b) ? word : 32'hBADB_AD01;
      tick();
    end
    clear_inputs();
    m_inst = word;
    tick();
    if (brk) begin
      m_instret = wrap(m_instret + 32'd1);
      m_stop = 1'b1;
      e_halt = 1'b1;
      return;
    end
    if (is_ld || is_st) begin
      for (int t = 0; t <= c; t++) begin
        e_dvalid = 1'b1; e_we = is_st;
        imem_req_ready = 1'b1;
        dmem_req_ready = (t == c);
        dmem_rsp_valid = (t == c);
        dmem_rsp_data  = 32'hBAD0_BAD2;
        tick();
      end
      e_dvalid = 1'b0; e_we = 1'b0;
      clear_inputs();
      for (int t = 0; t <= d; t++) begin
        dmem_rsp_valid = (t == d);
        dmem_rsp_data  = (t == d) ? rdata : 32'hBAD0_BAD3;
        if (abort) begin
          dmem_rsp_valid = 1'b0;
          #2;
          rst = 1'b0;
          #1;
          model_reset();
          check("abort imem_req_valid", 32'(imem_req_valid), 32'd0);
          check("abort dmem_req_valid", 32'(dmem_req_valid), 32'd0);
          check("abort pc", pc, RPC);
          check("abort load_data", load_data, 32'd0);
          check("abort instret", 32'(instret_cnt), 32'd0);
          return;
        end
        tick();
      end
      clear_inputs();
      if (is_ld) m_ld = rdata;
    end
    e_wen = wen;
    tick();
    e_wen = 1'b0;
    m_pc = nxt;
    m_instret = wrap(m_instret + 32'd1);
    if (nxt[1:0] != 2'b00) begin
      m_stop = 1'b1;
      e_err = 1'b1;
      e_ivalid = 1'b0;
    end else begin
      e_ivalid = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = 1'b1; dmem_req_ready = 1'b1;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    rst = 1'b0;
    chk_en = 1'b1;
    release_reset();

    // Single ALU op, 1-cycle memories
    run_inst(I_ADDI, 0, 0, 0, 0, 32'd0, 1'b0);
    check("t1 pc", pc, 32'h8000_0004);
    check("t1 instret", 32'(instret_cnt), 32'd1);
    check("t1 cycle_cnt", 32'(cycle_cnt), 32'd4);

    // Load with stalled request and delayed response, then a store leaving load_data alone
    run_inst(I_LW, 0, 0, 3, 2, 32'hDEAD_BEEF, 1'b0);
    check("t2 load_data", load_data, 32'hDEAD_BEEF);
    run_inst(I_SW, 1, 2, 0, 0, 32'h1234_5678, 1'b0);
    check("t2 store keeps load_data", load_data, 32'hDEAD_BEEF);

    // Fetch accepted on the very last cycle before timeout
    run_inst(I_ADDI, 7, 3, 0, 0, 32'd0, 1'b0);

    // ebreak halts, retires, freezes cycle count
    run_inst(I_EBRK, 0, 0, 0, 0, 32'd0, 1'b0);
    idle(4);
    check("t3 halt", 32'(halt), 32'd1);
    check("t3 instret", 32'(instret_cnt), 32'd5);
    check("t3 cycle_cnt frozen", 32'(cycle_cnt), 32'd9);

    // Fetch never accepted: timeout after 8 FETCH cycles
    do_reset();
    for (int t = 0; t < 8; t++) begin
      e_ivalid = 1'b1;
      tick();
    end
    m_stop = 1'b1; e_ivalid = 1'b0; e_err = 1'b1;
    idle(3);
    check("t4 err", 32'(err), 32'd1);
    check("t4 pc", pc, 32'h8000_0000);
    check("t4 cycle_cnt", 32'(cycle_cnt), 32'd8);

    // Misaligned next PC commits then errors
    do_reset();
    run_inst(I_JAL2, 0, 0, 0, 0, 32'd0, 1'b0);
    idle(3);
    check("t5 err", 32'(err), 32'd1);
    check("t5 pc", pc, 32'h8000_0002);
    check("t5 instret", 32'(instret_cnt), 32'd1);

    // Reset asserted during MWAIT, then restart from RESET_PC
    do_reset();
    run_inst(I_LW, 0, 0, 0, 0, 32'hCAFE_F00D, 1'b0);
    run_inst(I_LW, 0, 1, 1, 2, 32'h5555_AAAA, 1'b1);
    release_reset();
    run_inst(I_ADDI, 0, 0, 0, 0, 32'd0, 1'b0);
    check("t6 pc", pc, 32'h8000_0004);
    check("t6 instret", 32'(instret_cnt), 32'd1);

    // 20 ALU ops wrap the 4-bit retire counter
    do_reset();
    for (int i = 0; i < 20; i++) run_inst(I_ADDI, 0, 0, 0, 0, 32'd0, 1'b0);
    check("t7 instret wrap", 32'(instret_cnt), 32'd4);
    check("t7 pc", pc, 32'h8000_0050);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
